// File: rtl/mdio_pkg.sv
// Shared MDIO frame definitions (FSM encoding, ST/OP codes, status bit index) for responder and master.
// Latency: n/a. Backpressure: n/a.
package mdio_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_OP,
        S_PHYAD,
        S_REGAD,
        S_TA,
        S_WDATA,
        S_RDATA
    } mdio_state_t;

    localparam logic [1:0] MDIO_OP_READ  = 2'b10;
    localparam logic [1:0] MDIO_OP_WRITE = 2'b01;
    localparam logic [1:0] MDIO_ST       = 2'b01;
    localparam int         REG1_LINK_BIT = 2;

endpackage

// File: rtl/mdio_edge_sync.sv
// Two-flop synchronizer for an asynchronous input plus rise/fall detection on the synchronized level.
// Latency: 2 clk to dout, edge strobes one clk wide. Backpressure: none.
// Flops reset to 1 so an idle (pulled-up) line produces no spurious edge.
module mdio_edge_sync (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic dout,
    output logic rise,
    output logic fall
);

    logic s1, s2, s3;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1 <= 1'b1;
            s2 <= 1'b1;
            s3 <= 1'b1;
        end else begin
            s1 <= din;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign dout = s2;
    assign rise = s2 & ~s3;
    assign fall = ~s2 & s3;

endmodule

// File: rtl/mdio_slave.sv
// MDIO responder with a 32x16 register file; define MDIO_SLAVE_PREAMBLE_CHECK_EN to demand a full 32-bit preamble.
// Latency: ~3 clk from an mdc edge to sample/drive; register writes commit 1 clk after the last data-bit rise.
// Backpressure: none; the management master paces all traffic through mdc.
module mdio_slave
    import mdio_pkg::*;
#(
    parameter logic [4:0]  PHY_ADDR   = 5'd1,
    parameter logic [15:0] REG1_FIXED = 16'h7809
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mdc,
    input  logic        mdio_i,
    output logic        mdio_o,
    output logic        mdio_oe,
    input  logic        link_up,
    output logic [15:0] ctrl_reg,
    output logic        wr_pulse,
    output logic [4:0]  wr_addr
);

    logic mdc_rise, mdc_fall, mdio_s;
    logic unused_mdc_lvl, unused_mdio_rise, unused_mdio_fall;

    mdio_edge_sync u_mdc_sync (
        .clk  (clk),
        .rst  (rst),
        .din  (mdc),
        .dout (unused_mdc_lvl),
        .rise (mdc_rise),
        .fall (mdc_fall)
    );

    mdio_edge_sync u_mdio_sync (
        .clk  (clk),
        .rst  (rst),
        .din  (mdio_i),
        .dout (mdio_s),
        .rise (unused_mdio_rise),
        .fall (unused_mdio_fall)
    );

    mdio_state_t state, state_nxt;
    logic [4:0]  bit_cnt;
    logic [5:0]  ones_cnt;
    logic [1:0]  op;
    logic [4:0]  phy_sh, reg_sh, rd_addr;
    logic [15:0] data_sh, rd_word;
    logic [15:0] regs [32];
    logic        commit_pend, preamble_ok, field_last;

    assign rd_addr  = {reg_sh[3:0], mdio_s};
    assign ctrl_reg = regs[0];

`ifdef MDIO_SLAVE_PREAMBLE_CHECK_EN
    assign preamble_ok = (ones_cnt == 6'd32);
`else
    assign preamble_ok = (ones_cnt != 6'd0);
`endif

    // Register 1 is synthesised on the fly; its storage slot is never written.
    always_comb begin
        rd_word = regs[rd_addr];
        if (rd_addr == 5'd1) begin
            rd_word                = REG1_FIXED;
            rd_word[REG1_LINK_BIT] = link_up;
        end
    end

    always_comb begin
        field_last = 1'b0;
        case (state)
            S_OP, S_TA:       field_last = (bit_cnt == 5'd1);
            S_PHYAD, S_REGAD: field_last = (bit_cnt == 5'd4);
            S_WDATA:          field_last = (bit_cnt == 5'd15);
            default:          field_last = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (mdc_rise) begin
            case (state)
                S_IDLE:  if (mdio_s == MDIO_ST[1] && preamble_ok) state_nxt = S_START;
                S_START: state_nxt = (mdio_s == MDIO_ST[0]) ? S_OP : S_IDLE;
                S_OP:    if (field_last)
                             state_nxt = ({op[0], mdio_s} == MDIO_OP_READ ||
                                          {op[0], mdio_s} == MDIO_OP_WRITE) ? S_PHYAD : S_IDLE;
                S_PHYAD: if (field_last) state_nxt = S_REGAD;
                S_REGAD: if (field_last) state_nxt = (phy_sh == PHY_ADDR) ? S_TA : S_IDLE;
                S_TA:    if (field_last) state_nxt = (op == MDIO_OP_READ) ? S_RDATA : S_WDATA;
                S_WDATA: if (field_last) state_nxt = S_IDLE;
                default: state_nxt = state;
            endcase
        end else if (mdc_fall && state == S_RDATA && bit_cnt == 5'd16) begin
            state_nxt = S_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bit_cnt     <= '0;
            ones_cnt    <= '0;
            op          <= '0;
            phy_sh      <= '0;
            reg_sh      <= '0;
            data_sh     <= '0;
            commit_pend <= 1'b0;
            mdio_o      <= 1'b0;
            mdio_oe     <= 1'b0;
            wr_pulse    <= 1'b0;
            wr_addr     <= '0;
            for (int i = 0; i < 32; i++) regs[i] <= '0;
        end else begin
            wr_pulse    <= 1'b0;
            commit_pend <= 1'b0;
            if (commit_pend && reg_sh != 5'd1) begin
                wr_pulse <= 1'b1;
                wr_addr  <= reg_sh;
                if (reg_sh == 5'd0 && data_sh[15]) begin
                    for (int i = 0; i < 32; i++) regs[i] <= '0;
                end else begin
                    regs[reg_sh] <= data_sh;
                end
            end

            if (mdc_rise) begin
                case (state)
                    S_IDLE:  ones_cnt <= !mdio_s ? 6'd0 :
                                         (ones_cnt == 6'd32) ? ones_cnt : ones_cnt + 6'd1;
                    S_START: ones_cnt <= 6'd0;
                    S_OP:    op <= {op[0], mdio_s};
                    S_PHYAD: phy_sh <= {phy_sh[3:0], mdio_s};
                    S_REGAD: begin
                        reg_sh <= rd_addr;
                        // Snapshot here so link_up moving mid-read cannot tear the word.
                        if (field_last) data_sh <= rd_word;
                    end
                    S_WDATA: begin
                        data_sh <= {data_sh[14:0], mdio_s};
                        if (field_last) commit_pend <= 1'b1;
                    end
                    default: ;
                endcase
                if (state inside {S_OP, S_PHYAD, S_REGAD, S_TA, S_WDATA})
                    bit_cnt <= field_last ? 5'd0 : bit_cnt + 5'd1;
            end

            if (mdc_fall) begin
                if (state == S_TA && bit_cnt == 5'd1 && op == MDIO_OP_READ) begin
                    mdio_oe <= 1'b1;
                    mdio_o  <= 1'b0;
                end else if (state == S_RDATA) begin
                    if (bit_cnt == 5'd16) begin
                        mdio_oe <= 1'b0;
                        mdio_o  <= 1'b0;
                        bit_cnt <= 5'd0;
                    end else begin
                        mdio_o  <= data_sh[15];
                        data_sh <= {data_sh[14:0], 1'b0};
                        bit_cnt <= bit_cnt + 5'd1;
                    end
                end
            end
        end
    end

endmodule
